ca_sequencer: RTL
=================

Name: ca_sequencer

Overview:
- Control sequencer for the coherent-average accumulator used ahead of the lock-in stage.
- Locks acquisition to the period reference and indexes samples within each period.
- Drives accumulate/write strobes and addresses to the averaging RAM for 2^M_LOG2 periods.
- Then streams the accumulated buffer out to the lock-in with a valid/ready handshake.
- Sits between the ADC sample stream and the accumulator RAM; the start/enable controls come from board switches and keys.

Parameters:
N_LOG2, 13, log2 of samples per period (N = 8192)
M_LOG2, 7, log2 of periods averaged (M = 128)
CONTINUOUS, 0, 1 = re-arm automatically after DONE instead of returning to IDLE

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
enable  in  1  run enable; low aborts any run
start  in  1  one-cycle start request
trig  in  1  period reference; high with data_valid marks sample 0 of a period
data_valid  in  1  ADC sample strobe
acc_en  out  1  accumulate strobe to RAM (registered)
acc_first  out  1  1 = write the sample (frame 0); 0 = add it to the stored value
acc_addr  out  N_LOG2  sample index within period
frame_cnt  out  M_LOG2  current period number
rd_valid  out  1  readout beat valid
rd_ready  in  1  downstream accepts beat
rd_addr  out  N_LOG2  readout RAM address
rd_last  out  1  final readout beat (rd_addr = N-1)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of readout
sync_err  out  1  sticky flag: trig seen at a nonzero index

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; idx=0.
- States are IDLE, ARM, ACQ, READ, DONE.
- IDLE:
  - start && enable -> ARM.
  - On that transition: frame_cnt=0, idx=0, sync_err cleared.
  - start is ignored in every other state.
- ARM:
  - Waits for data_valid && trig.
  - That sample is index 0 of frame 0: next cycle acc_en=1, acc_addr=0, acc_first=1. Then idx=1, go to ACQ.
  - data_valid without trig is discarded.
- ACQ:
  - Each data_valid produces, one cycle later, acc_en=1 with acc_addr=idx and acc_first=(frame_cnt==0).
  - Latency is exactly 1 cycle; the datapath delays sample data by 1 register to match.
  - acc_en is low on cycles without a preceding data_valid.
  - idx increments per data_valid and wraps N-1 -> 0; frame_cnt increments on the wrap.
  - The sample with idx=N-1 and frame_cnt=M-1 is the last one accumulated.
  - After it, go to READ, with frame_cnt holding M-1 through READ.
  - data_valid is ignored during READ.
  - trig with data_valid at idx != 0 sets sync_err. Indexing is not resynchronised; the run continues.
- READ:
  - rd_valid=1 from the first READ cycle, with rd_addr starting at 0.
  - rd_addr advances only on rd_valid && rd_ready, and holds stable under backpressure.
  - rd_last=1 while rd_addr=N-1.
  - Handshake on the last beat: rd_valid drops next cycle, go to DONE.
  - The entry cycle into READ must not overlap the final acc_en write, which precedes it by at least 1 cycle.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is ARM if CONTINUOUS=1 (frame_cnt=0, idx=0), else IDLE.
- enable=0 in any state except IDLE:
  - Next cycle state is IDLE.
  - acc_en, rd_valid, rd_last, busy are 0; done does not pulse; counters are cleared.
  - An acc_en already registered completes in that same cycle.
- sync_err holds until the next accepted start or reset.
- Counters are unsigned and wrap only as described; no overflow at frame_cnt=M-1 because the state exits.
- Simultaneous trig and data_valid on the wrap sample (idx wraps to 0) is the normal aligned case and sets no error.

Test Plan:
1. Reset, scenario 1: reset_n low mid-ACQ -> all outputs 0 immediately (asynchronous), state IDLE; start afterwards runs normally.
2. Full run, scenario 2: N_LOG2=3, M_LOG2=2, data_valid every cycle, trig every 8th sample.
   - 32 acc_en pulses; acc_addr sequence 0..7 four times.
   - acc_first=1 only on the first 8 pulses; frame_cnt steps 0,1,2,3.
   - Then 8 readout beats with rd_last on beat 8, then done for one cycle and busy low.
3. Gapped input, scenario 3: data_valid 1 cycle in 3 and a 5-cycle ARM wait with non-trig samples -> same 32 acc_en pulses at the same addresses, each 1 cycle after its data_valid; pre-trig samples dropped.
4. Backpressure, scenario 4: rd_ready toggled 0,0,1 repeatedly -> rd_addr stable while rd_ready=0; exactly 8 accepted beats, addresses 0..7, no duplicates.
5. Abort and retry, scenario 5:
   - enable dropped at frame_cnt=1, idx=4 -> IDLE next cycle, no done, busy=0.
   - Re-enable plus start -> fresh run with acc_first=1 at address 0.
6. Misaligned trig and CONTINUOUS, scenario 6:
   - trig injected with data_valid at idx=3 -> sync_err=1 and stays 1 to DONE; next start clears it.
   - With CONTINUOUS=1, DONE is followed by ARM with no start needed.

Source files
------------

// File: rtl/ca_sequencer.sv
// Control sequencer for the coherent-average accumulator: locks to the period
// reference, strobes 2^M_LOG2 periods of samples into the averaging RAM, then streams the buffer out.
module ca_sequencer #(
  parameter int N_LOG2     = 13,
  parameter int M_LOG2     = 7,
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              trig,
  input  logic              data_valid,
  output logic              acc_en,
  output logic              acc_first,
  output logic [N_LOG2-1:0] acc_addr,
  output logic [M_LOG2-1:0] frame_cnt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              sync_err
);

  localparam logic [N_LOG2-1:0] IDX_MAX = '1;
  localparam logic [M_LOG2-1:0] FRM_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_ACQ  = 3'd2,
    S_READ = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_LOG2-1:0]   r_idx;
  logic [N_LOG2-1:0]   w_idx_nxt;
  logic [M_LOG2-1:0]   r_frame;
  logic [M_LOG2-1:0]   w_frame_nxt;
  logic                r_flush;
  logic                w_flush_nxt;
  logic                r_acc_en;
  logic                w_acc_en_nxt;
  logic                r_acc_first;
  logic                w_acc_first_nxt;
  logic [N_LOG2-1:0]   r_acc_addr;
  logic [N_LOG2-1:0]   w_acc_addr_nxt;
  logic [N_LOG2-1:0]   r_rd_addr;
  logic [N_LOG2-1:0]   w_rd_addr_nxt;
  logic                r_sync_err;
  logic                w_sync_err_nxt;
  logic                w_abort;

  assign w_abort = !enable && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_frame     <= '0;
      r_flush     <= 1'b0;
      r_acc_en    <= 1'b0;
      r_acc_first <= 1'b0;
      r_acc_addr  <= '0;
      r_rd_addr   <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame     <= w_frame_nxt;
      r_flush     <= w_flush_nxt;
      r_acc_en    <= w_acc_en_nxt;
      r_acc_first <= w_acc_first_nxt;
      r_acc_addr  <= w_acc_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_frame_nxt     = r_frame;
    w_flush_nxt     = r_flush;
    w_acc_en_nxt    = 1'b0;
    w_acc_first_nxt = r_acc_first;
    w_acc_addr_nxt  = r_acc_addr;
    w_rd_addr_nxt   = r_rd_addr;
    w_sync_err_nxt  = r_sync_err;

    case (r_state)
      S_IDLE: begin
        if (start && enable) begin
          w_state_nxt    = S_ARM;
          w_idx_nxt      = '0;
          w_frame_nxt    = '0;
          w_flush_nxt    = 1'b0;
          w_rd_addr_nxt  = '0;
          w_sync_err_nxt = 1'b0;
        end
      end

      S_ARM: begin
        if (data_valid && trig) begin
          w_acc_en_nxt    = 1'b1;
          w_acc_addr_nxt  = '0;
          w_acc_first_nxt = 1'b1;
          w_idx_nxt       = N_LOG2'(1);
          w_state_nxt     = S_ACQ;
        end
      end

      S_ACQ: begin
        // One-cycle gap so the final RAM write completes before readout starts.
        if (r_flush) begin
          w_flush_nxt = 1'b0;
          w_state_nxt = S_READ;
        end else if (data_valid) begin
          w_acc_en_nxt    = 1'b1;
          w_acc_addr_nxt  = r_idx;
          w_acc_first_nxt = (r_frame == '0);
          w_idx_nxt       = r_idx + N_LOG2'(1);
          if (trig && (r_idx != '0)) begin
            w_sync_err_nxt = 1'b1;
          end
          if (r_idx == IDX_MAX) begin
            if (r_frame == FRM_MAX) begin
              w_flush_nxt = 1'b1;
            end else begin
              w_frame_nxt = r_frame + M_LOG2'(1);
            end
          end
        end
      end

      S_READ: begin
        if (rd_ready) begin
          if (r_rd_addr == IDX_MAX) begin
            w_rd_addr_nxt = '0;
            w_state_nxt   = S_DONE;
          end else begin
            w_rd_addr_nxt = r_rd_addr + N_LOG2'(1);
          end
        end
      end

      S_DONE: begin
        w_idx_nxt   = '0;
        w_frame_nxt = '0;
        w_state_nxt = (CONTINUOUS != 0) ? S_ARM : S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Dropping enable wins over everything; sync_err is kept for inspection.
    if (w_abort) begin
      w_state_nxt   = S_IDLE;
      w_acc_en_nxt  = 1'b0;
      w_idx_nxt     = '0;
      w_frame_nxt   = '0;
      w_flush_nxt   = 1'b0;
      w_rd_addr_nxt = '0;
    end
  end

  assign acc_en    = r_acc_en;
  assign acc_first = r_acc_first;
  assign acc_addr  = r_acc_addr;
  assign frame_cnt = r_frame;
  assign rd_valid  = (r_state == S_READ);
  assign rd_addr   = r_rd_addr;
  assign rd_last   = (r_state == S_READ) && (r_rd_addr == IDX_MAX);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign sync_err  = r_sync_err;

endmodule
